// File: rtl/bp_lce_sync_responder.sv
// LCE-side endpoint of the CCE sync handshake: absorbs sync commands, answers each
// with a sync-ack response, and forwards every other command (header and data) unchanged.
module bp_lce_sync_responder
  #(parameter int num_cce_p        = 4
  , parameter int lce_id_width_p   = 4
  , parameter int cce_id_width_p   = 3
  , parameter int paddr_width_p    = 16
  , parameter int lce_assoc_p      = 8
  , parameter int lce_data_width_p = 64
  , localparam int way_id_width_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
  , localparam int lce_cmd_msg_header_width_lp =
      3 + way_id_width_lp + cce_id_width_p + lce_id_width_p + 3 + paddr_width_p + 4 + 4
  , localparam int lce_resp_msg_header_width_lp =
      lce_id_width_p + cce_id_width_p + 3 + paddr_width_p + 4 + 4
  , localparam int sync_cnt_width_lp = $clog2(num_cce_p + 1)
  )
  (input  logic                                    clk_i
  , input  logic                                   reset_i
  , input  logic [lce_id_width_p-1:0]              lce_id_i

  , input  logic [lce_cmd_msg_header_width_lp-1:0] lce_cmd_header_i
  , input  logic                                   lce_cmd_header_v_i
  , output logic                                   lce_cmd_header_ready_and_o
  , input  logic                                   lce_cmd_has_data_i
  , input  logic [lce_data_width_p-1:0]            lce_cmd_data_i
  , input  logic                                   lce_cmd_data_v_i
  , output logic                                   lce_cmd_data_ready_and_o
  , input  logic                                   lce_cmd_last_i

  , output logic [lce_cmd_msg_header_width_lp-1:0] fwd_cmd_header_o
  , output logic                                   fwd_cmd_header_v_o
  , input  logic                                   fwd_cmd_header_ready_and_i
  , output logic                                   fwd_cmd_has_data_o
  , output logic [lce_data_width_p-1:0]            fwd_cmd_data_o
  , output logic                                   fwd_cmd_data_v_o
  , input  logic                                   fwd_cmd_data_ready_and_i
  , output logic                                   fwd_cmd_last_o

  , output logic [lce_resp_msg_header_width_lp-1:0] lce_resp_header_o
  , output logic                                    lce_resp_header_v_o
  , input  logic                                    lce_resp_header_ready_and_i
  , output logic                                    lce_resp_has_data_o
  , output logic [lce_data_width_p-1:0]             lce_resp_data_o
  , output logic                                    lce_resp_data_v_o
  , output logic                                    lce_resp_last_o

  , output logic [sync_cnt_width_lp-1:0]            sync_cnt_o
  , output logic                                    sync_done_o
  );

  localparam logic [3:0] e_bedrock_cmd_sync      = 4'h0;
  localparam logic [3:0] e_bedrock_resp_sync_ack = 4'h0;
  localparam logic [2:0] e_bedrock_msg_size_1    = 3'b000;
  localparam logic [sync_cnt_width_lp-1:0] num_cce_lp = sync_cnt_width_lp'(num_cce_p);

  typedef struct packed {
    logic [2:0]                 state;
    logic [way_id_width_lp-1:0] way_id;
    logic [cce_id_width_p-1:0]  src_id;
    logic [lce_id_width_p-1:0]  dst_id;
  } cmd_payload_s;

  typedef struct packed {
    cmd_payload_s              payload;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                subop;
    logic [3:0]                msg_type;
  } cmd_header_s;

  typedef struct packed {
    logic [lce_id_width_p-1:0] src_id;
    logic [cce_id_width_p-1:0] dst_id;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                subop;
    logic [3:0]                msg_type;
  } resp_header_s;

  typedef enum logic [1:0] {
    e_ready    = 2'd0,
    e_send_ack = 2'd1,
    e_fwd_data = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [cce_id_width_p-1:0]   src_id_q, src_id_d;
  logic [paddr_width_p-1:0]    addr_q, addr_d;
  logic [sync_cnt_width_lp-1:0] sync_cnt_q, sync_cnt_d;

  cmd_header_s  cmd_hdr;
  resp_header_s resp_hdr;
  logic         is_sync;

  assign cmd_hdr = cmd_header_s'(lce_cmd_header_i);
  assign is_sync = (cmd_hdr.msg_type == e_bedrock_cmd_sync);

  // The ack header is built only from latched fields and the static LCE id, so it is stable while stalled
  always_comb begin
    resp_hdr          = '0;
    resp_hdr.msg_type = e_bedrock_resp_sync_ack;
    resp_hdr.src_id   = lce_id_i;
    resp_hdr.dst_id   = src_id_q;
    resp_hdr.addr     = addr_q;
    resp_hdr.size     = e_bedrock_msg_size_1;
  end

  assign fwd_cmd_header_o    = cmd_hdr;
  assign fwd_cmd_has_data_o  = lce_cmd_has_data_i;
  assign fwd_cmd_data_o      = lce_cmd_data_i;
  assign fwd_cmd_last_o      = lce_cmd_last_i;
  assign lce_resp_header_o   = resp_hdr;
  assign lce_resp_has_data_o = 1'b0;
  assign lce_resp_data_o     = {lce_data_width_p{1'b0}};
  assign lce_resp_data_v_o   = 1'b0;
  assign lce_resp_last_o     = 1'b0;
  assign sync_cnt_o          = sync_cnt_q;
  assign sync_done_o         = (sync_cnt_q == num_cce_lp);

  // Handshake steering and next-state; all valids/readies held low while in reset
  always_comb begin
    state_d                    = state_q;
    src_id_d                   = src_id_q;
    addr_d                     = addr_q;
    sync_cnt_d                 = sync_cnt_q;
    lce_cmd_header_ready_and_o = 1'b0;
    lce_cmd_data_ready_and_o   = 1'b0;
    fwd_cmd_header_v_o         = 1'b0;
    fwd_cmd_data_v_o           = 1'b0;
    lce_resp_header_v_o        = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        e_ready: begin
          if (is_sync) begin
            lce_cmd_header_ready_and_o = 1'b1;
            if (lce_cmd_header_v_i) begin
              src_id_d = cmd_hdr.payload.src_id;
              addr_d   = cmd_hdr.addr;
              state_d  = e_send_ack;
            end else begin
              state_d  = e_ready;
            end
          end else begin
            fwd_cmd_header_v_o         = lce_cmd_header_v_i;
            lce_cmd_header_ready_and_o = fwd_cmd_header_ready_and_i;
            if (lce_cmd_header_v_i && fwd_cmd_header_ready_and_i && lce_cmd_has_data_i) begin
              state_d = e_fwd_data;
            end else begin
              state_d = e_ready;
            end
          end
        end
        e_send_ack: begin
          lce_resp_header_v_o = 1'b1;
          if (lce_resp_header_ready_and_i) begin
            sync_cnt_d = (sync_cnt_q == num_cce_lp) ? sync_cnt_q
                                                    : sync_cnt_q + sync_cnt_width_lp'(1);
            state_d    = e_ready;
          end else begin
            state_d    = e_send_ack;
          end
        end
        e_fwd_data: begin
          fwd_cmd_data_v_o         = lce_cmd_data_v_i;
          lce_cmd_data_ready_and_o = fwd_cmd_data_ready_and_i;
          if (lce_cmd_data_v_i && fwd_cmd_data_ready_and_i && lce_cmd_last_i) begin
            state_d = e_ready;
          end else begin
            state_d = e_fwd_data;
          end
        end
        default: begin
          state_d = e_ready;
        end
      endcase
    end else begin
      state_d = e_ready;
    end
  end

  // State, latched sync source and ack counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_ready;
      src_id_q   <= '0;
      addr_q     <= '0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      src_id_q   <= src_id_d;
      addr_q     <= addr_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  bp_lce_sync_responder_chk
    #(.hdr_width_p(lce_resp_msg_header_width_lp))
    chk
    (.clk_i              (clk_i)
    ,.reset_i            (reset_i)
    ,.sync_hs_i          (is_sync && lce_cmd_header_v_i && lce_cmd_header_ready_and_o)
    ,.has_data_i         (lce_cmd_has_data_i)
    ,.resp_v_i           (lce_resp_header_v_o)
    ,.resp_ready_and_i   (lce_resp_header_ready_and_i)
    ,.resp_header_i      (lce_resp_header_o)
    );

endmodule

// Protocol checks for the sync responder: data-carrying syncs and unstable stalled acks.
module bp_lce_sync_responder_chk
  #(parameter int hdr_width_p = 1)
  (input logic                   clk_i
  , input logic                  reset_i
  , input logic                  sync_hs_i
  , input logic                  has_data_i
  , input logic                  resp_v_i
  , input logic                  resp_ready_and_i
  , input logic [hdr_width_p-1:0] resp_header_i
  );

  sync_no_data_a: assert property (@(posedge clk_i) disable iff (reset_i)
    sync_hs_i |-> !has_data_i);

  resp_stable_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (resp_v_i && !resp_ready_and_i) |=> (resp_v_i && $stable(resp_header_i)));

endmodule

// File: tb/tb_bp_lce_sync_responder.sv
// Directed bench for bp_lce_sync_responder: a cycle table plus hand-written stall,
// saturation and reset sequences.
module tb_bp_lce_sync_responder;
  localparam int cmd_w  = 40;
  localparam int resp_w = 34;
  localparam int data_w = 64;
  localparam logic [3:0] t_sync = 4'h0;
  localparam logic [3:0] t_inv  = 4'h2;
  localparam logic [3:0] t_st   = 4'h3;
  localparam logic [3:0] my_lce = 4'd5;

  logic clk_i = 1'b0;
  logic reset_i;
  logic [3:0] lce_id_i;
  logic [cmd_w-1:0] lce_cmd_header_i;
  logic lce_cmd_header_v_i, lce_cmd_header_ready_and_o, lce_cmd_has_data_i;
  logic [data_w-1:0] lce_cmd_data_i;
  logic lce_cmd_data_v_i, lce_cmd_data_ready_and_o, lce_cmd_last_i;
  logic [cmd_w-1:0] fwd_cmd_header_o;
  logic fwd_cmd_header_v_o, fwd_cmd_header_ready_and_i, fwd_cmd_has_data_o;
  logic [data_w-1:0] fwd_cmd_data_o;
  logic fwd_cmd_data_v_o, fwd_cmd_data_ready_and_i, fwd_cmd_last_o;
  logic [resp_w-1:0] lce_resp_header_o;
  logic lce_resp_header_v_o, lce_resp_header_ready_and_i, lce_resp_has_data_o;
  logic [data_w-1:0] lce_resp_data_o;
  logic lce_resp_data_v_o, lce_resp_last_o;
  logic [2:0] sync_cnt_o;
  logic sync_done_o;

  int errors = 0;
  int checks = 0;

  bp_lce_sync_responder dut
    (.clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i)
    ,.lce_cmd_header_i(lce_cmd_header_i), .lce_cmd_header_v_i(lce_cmd_header_v_i)
    ,.lce_cmd_header_ready_and_o(lce_cmd_header_ready_and_o), .lce_cmd_has_data_i(lce_cmd_has_data_i)
    ,.lce_cmd_data_i(lce_cmd_data_i), .lce_cmd_data_v_i(lce_cmd_data_v_i)
    ,.lce_cmd_data_ready_and_o(lce_cmd_data_ready_and_o), .lce_cmd_last_i(lce_cmd_last_i)
    ,.fwd_cmd_header_o(fwd_cmd_header_o), .fwd_cmd_header_v_o(fwd_cmd_header_v_o)
    ,.fwd_cmd_header_ready_and_i(fwd_cmd_header_ready_and_i), .fwd_cmd_has_data_o(fwd_cmd_has_data_o)
    ,.fwd_cmd_data_o(fwd_cmd_data_o), .fwd_cmd_data_v_o(fwd_cmd_data_v_o)
    ,.fwd_cmd_data_ready_and_i(fwd_cmd_data_ready_and_i), .fwd_cmd_last_o(fwd_cmd_last_o)
    ,.lce_resp_header_o(lce_resp_header_o), .lce_resp_header_v_o(lce_resp_header_v_o)
    ,.lce_resp_header_ready_and_i(lce_resp_header_ready_and_i), .lce_resp_has_data_o(lce_resp_has_data_o)
    ,.lce_resp_data_o(lce_resp_data_o), .lce_resp_data_v_o(lce_resp_data_v_o)
    ,.lce_resp_last_o(lce_resp_last_o)
    ,.sync_cnt_o(sync_cnt_o), .sync_done_o(sync_done_o)
    );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        hv;
    logic [3:0]  typ;
    logic [2:0]  src;
    logic [15:0] addr;
    logic        hd;
    logic        fhr;
    logic        rr;
    logic        dv;
    logic [63:0] data;
    logic        last;
    logic        fdr;
    logic [4:0]  exp_flags; // {hdr_ready, fwd_hdr_v, resp_v, data_ready, fwd_data_v}
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mkv(input logic hv, input logic [3:0] typ, input logic [2:0] src,
                               input logic [15:0] addr, input logic hd, input logic fhr,
                               input logic rr, input logic dv, input logic [63:0] data,
                               input logic last, input logic fdr, input logic [4:0] f,
                               input logic [2:0] c);
    vec_t v;
    v.hv = hv; v.typ = typ; v.src = src; v.addr = addr; v.hd = hd; v.fhr = fhr; v.rr = rr;
    v.dv = dv; v.data = data; v.last = last; v.fdr = fdr; v.exp_flags = f; v.exp_cnt = c;
    return v;
  endfunction

  function automatic logic [cmd_w-1:0] mk_cmd(input logic [3:0] typ, input logic [2:0] src,
                                              input logic [15:0] addr);
    return {3'b000, 3'b000, src, 4'h0, 3'b000, addr, 4'h0, typ};
  endfunction

  function automatic logic [resp_w-1:0] mk_resp(input logic [2:0] dst, input logic [15:0] addr);
    return {my_lce, dst, 3'b000, addr, 4'h0, 4'h0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {lce_cmd_header_ready_and_o, fwd_cmd_header_v_o, lce_resp_header_v_o,
            lce_cmd_data_ready_and_o, fwd_cmd_data_v_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    lce_cmd_header_v_i = 1'b0; lce_cmd_header_i = mk_cmd(t_st, 3'd0, 16'h0);
    lce_cmd_has_data_i = 1'b0; lce_cmd_data_v_i = 1'b0; lce_cmd_data_i = '0;
    lce_cmd_last_i = 1'b0; fwd_cmd_header_ready_and_i = 1'b0;
    fwd_cmd_data_ready_and_i = 1'b0; lce_resp_header_ready_and_i = 1'b0;
  endtask

  // Offer a sync, check acceptance and the ack header, release with immediate ack ready
  task automatic send_sync(input logic [2:0] src, input logic [15:0] addr, input logic [2:0] cnt_before);
    lce_cmd_header_v_i = 1'b1; lce_cmd_header_i = mk_cmd(t_sync, src, addr);
    #1 check("sync_accept", {63'd0, lce_cmd_header_ready_and_o}, 64'd1);
    step();
    idle_inputs();
    lce_resp_header_ready_and_i = 1'b1;
    #1 check("ack_valid", {63'd0, lce_resp_header_v_o}, 64'd1);
    check("ack_header", {30'd0, lce_resp_header_o}, {30'd0, mk_resp(src, addr)});
    check("cnt_before_ack", {61'd0, sync_cnt_o}, {61'd0, cnt_before});
    step();
    lce_resp_header_ready_and_i = 1'b0;
  endtask

  initial begin
    lce_id_i = my_lce;
    idle_inputs();
    reset_i = 1'b1;
    vecs[0]  = mkv(1'b0, t_st,   3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b00000, 3'd0);
    vecs[1]  = mkv(1'b1, t_sync, 3'd2, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b10000, 3'd0);
    vecs[2]  = mkv(1'b0, t_st,   3'd2, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 5'b00100, 3'd0);
    vecs[3]  = mkv(1'b0, t_st,   3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b00000, 3'd1);
    vecs[4]  = mkv(1'b1, t_st,   3'd0, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b01000, 3'd1);
    vecs[5]  = mkv(1'b1, t_st,   3'd0, 16'h0400, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b11000, 3'd1);
    vecs[6]  = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd0, 1'b0, 1'b0, 5'b00001, 3'd1);
    vecs[7]  = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd0, 1'b0, 1'b1, 5'b00011, 3'd1);
    vecs[8]  = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd1, 1'b0, 1'b0, 5'b00001, 3'd1);
    vecs[9]  = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd1, 1'b0, 1'b1, 5'b00011, 3'd1);
    vecs[10] = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd2, 1'b0, 1'b0, 5'b00001, 3'd1);
    vecs[11] = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd2, 1'b0, 1'b1, 5'b00011, 3'd1);
    vecs[12] = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd3, 1'b1, 1'b0, 5'b00001, 3'd1);
    vecs[13] = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd3, 1'b1, 1'b1, 5'b00011, 3'd1);
    vecs[14] = mkv(1'b1, t_sync, 3'd1, 16'h00aa, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b10000, 3'd1);
    vecs[15] = mkv(1'b0, t_st,   3'd1, 16'h00aa, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 5'b00100, 3'd1);
    vecs[16] = mkv(1'b0, t_st,   3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b00000, 3'd2);
    vecs[17] = mkv(1'b1, t_inv,  3'd4, 16'h0bee, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 5'b11000, 3'd2);
    vecs[18] = mkv(1'b0, t_st,   3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 64'hd0, 1'b1, 1'b1, 5'b00000, 3'd2);

    // Reset: every valid and ready low even with all inputs asserted
    @(negedge clk_i);
    lce_cmd_header_v_i = 1'b1; lce_cmd_header_i = mk_cmd(t_sync, 3'd1, 16'h0);
    fwd_cmd_header_ready_and_i = 1'b1; lce_resp_header_ready_and_i = 1'b1;
    lce_cmd_data_v_i = 1'b1; fwd_cmd_data_ready_and_i = 1'b1;
    #1 check("reset_flags", {59'd0, flags()}, 64'd0);
    step();
    step();
    reset_i = 1'b0;
    idle_inputs();
    #1 check("reset_cnt", {61'd0, sync_cnt_o}, 64'd0);
    check("reset_done", {63'd0, sync_done_o}, 64'd0);
    check("resp_tieoffs", {lce_resp_data_o[60:0], lce_resp_has_data_o, lce_resp_data_v_o, lce_resp_last_o}, 64'd0);

    for (int i = 0; i < 19; i++) begin
      lce_cmd_header_v_i = vecs[i].hv;
      lce_cmd_header_i   = mk_cmd(vecs[i].typ, vecs[i].src, vecs[i].addr);
      lce_cmd_has_data_i = vecs[i].hd;
      fwd_cmd_header_ready_and_i  = vecs[i].fhr;
      lce_resp_header_ready_and_i = vecs[i].rr;
      lce_cmd_data_v_i   = vecs[i].dv;
      lce_cmd_data_i     = vecs[i].data;
      lce_cmd_last_i     = vecs[i].last;
      fwd_cmd_data_ready_and_i = vecs[i].fdr;
      #1;
      check($sformatf("row%0d_flags", i), {59'd0, flags()}, {59'd0, vecs[i].exp_flags});
      check($sformatf("row%0d_cnt", i), {61'd0, sync_cnt_o}, {61'd0, vecs[i].exp_cnt});
      if (vecs[i].exp_flags[2]) begin
        check($sformatf("row%0d_ack_hdr", i), {30'd0, lce_resp_header_o},
              {30'd0, mk_resp(vecs[i].src, vecs[i].addr)});
      end
      if (vecs[i].exp_flags[3]) begin
        check($sformatf("row%0d_fwd_hdr", i), {24'd0, fwd_cmd_header_o},
              {24'd0, mk_cmd(vecs[i].typ, vecs[i].src, vecs[i].addr)});
        check($sformatf("row%0d_fwd_has_data", i), {63'd0, fwd_cmd_has_data_o}, {63'd0, vecs[i].hd});
      end
      if (vecs[i].exp_flags[0]) begin
        check($sformatf("row%0d_fwd_data", i), fwd_cmd_data_o, vecs[i].data);
        check($sformatf("row%0d_fwd_last", i), {63'd0, fwd_cmd_last_o}, {63'd0, vecs[i].last});
      end
      step();
    end
    idle_inputs();

    // Third sync with the ack stalled for three cycles
    lce_cmd_header_v_i = 1'b1; lce_cmd_header_i = mk_cmd(t_sync, 3'd3, 16'h0300);
    #1 check("stall_accept", {63'd0, lce_cmd_header_ready_and_o}, 64'd1);
    step();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("stall%0d_valid", k), {63'd0, lce_resp_header_v_o}, 64'd1);
      check($sformatf("stall%0d_hdr", k), {30'd0, lce_resp_header_o}, {30'd0, mk_resp(3'd3, 16'h0300)});
      check($sformatf("stall%0d_in_ready", k), {63'd0, lce_cmd_header_ready_and_o}, 64'd0);
      check($sformatf("stall%0d_cnt", k), {61'd0, sync_cnt_o}, 64'd2);
      step();
    end
    lce_resp_header_ready_and_i = 1'b1;
    #1 check("stall_release_valid", {63'd0, lce_resp_header_v_o}, 64'd1);
    step();
    lce_resp_header_ready_and_i = 1'b0;
    #1 check("after_stall_valid", {63'd0, lce_resp_header_v_o}, 64'd0);
    check("after_stall_cnt", {61'd0, sync_cnt_o}, 64'd3);
    check("after_stall_done", {63'd0, sync_done_o}, 64'd0);

    // Fourth sync raises done; a fifth is still acked and the count saturates
    send_sync(3'd0, 16'h0000, 3'd3);
    #1 check("fourth_cnt", {61'd0, sync_cnt_o}, 64'd4);
    check("fourth_done", {63'd0, sync_done_o}, 64'd1);
    send_sync(3'd2, 16'h0500, 3'd4);
    #1 check("fifth_cnt", {61'd0, sync_cnt_o}, 64'd4);
    check("fifth_done", {63'd0, sync_done_o}, 64'd1);
    check("fifth_no_resp", {63'd0, lce_resp_header_v_o}, 64'd0);

    // Reset while an ack is pending abandons it
    lce_cmd_header_v_i = 1'b1; lce_cmd_header_i = mk_cmd(t_sync, 3'd1, 16'h0777);
    step();
    #1 check("pre_reset_valid", {63'd0, lce_resp_header_v_o}, 64'd1);
    reset_i = 1'b1;
    #1 check("in_reset_flags", {59'd0, flags()}, 64'd0);
    step();
    reset_i = 1'b0;
    lce_cmd_header_v_i = 1'b0; lce_cmd_header_i = mk_cmd(t_sync, 3'd0, 16'h0);
    lce_resp_header_ready_and_i = 1'b1;
    #1 check("post_reset_valid", {63'd0, lce_resp_header_v_o}, 64'd0);
    check("post_reset_cnt", {61'd0, sync_cnt_o}, 64'd0);
    check("post_reset_done", {63'd0, sync_done_o}, 64'd0);
    check("post_reset_ready_state", {63'd0, lce_cmd_header_ready_and_o}, 64'd1);
    step();
    #1 check("post_reset_valid2", {63'd0, lce_resp_header_v_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_lce_sync_responder.md
Name: bp_lce_sync_responder

Overview:
- LCE-side endpoint for the CCE sync handshake. It sits between the LCE command network input and the LCE command-processing logic.
- Sync commands (e_bedrock_cmd_sync) are consumed here and answered with one sync-ack on the LCE response channel, addressed to the issuing CCE.
- All other commands, header and data, are forwarded unchanged to the downstream command logic.
- It counts acked syncs and raises sync_done_o once every CCE in the system has synced this LCE.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies num_cce_p, lce_id_width_p, cce_id_width_p, paddr_width_p, lce_assoc_p.
- lce_data_width_p, dword_width_gp, width of one command data beat.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- lce_id_i  in  lce_id_width_p  this LCE's id; static after reset
- lce_cmd_header_i  in  lce_cmd_msg_header_width_lp  incoming command header
- lce_cmd_header_v_i  in  1  header valid
- lce_cmd_header_ready_and_o  out  1  header ready
- lce_cmd_has_data_i  in  1  command carries data beats
- lce_cmd_data_i  in  lce_data_width_p  data beat
- lce_cmd_data_v_i  in  1  data valid
- lce_cmd_data_ready_and_o  out  1  data ready
- lce_cmd_last_i  in  1  final data beat
- fwd_cmd_header_o  out  lce_cmd_msg_header_width_lp  forwarded header
- fwd_cmd_header_v_o  out  1
- fwd_cmd_header_ready_and_i  in  1
- fwd_cmd_has_data_o  out  1
- fwd_cmd_data_o  out  lce_data_width_p
- fwd_cmd_data_v_o  out  1
- fwd_cmd_data_ready_and_i  in  1
- fwd_cmd_last_o  out  1
- lce_resp_header_o  out  lce_resp_msg_header_width_lp  sync-ack header
- lce_resp_header_v_o  out  1
- lce_resp_header_ready_and_i  in  1
- lce_resp_has_data_o, lce_resp_data_v_o, lce_resp_last_o  out  1 each  tied 0
- lce_resp_data_o  out  lce_data_width_p  tied 0
- sync_cnt_o  out  BSG_WIDTH(num_cce_p)  number of sync-acks accepted
- sync_done_o  out  1  sync_cnt_o == num_cce_p

Behaviour:
- All interfaces use BedRock burst ready&valid. A handshake occurs when v & ready_and are both high in the same cycle.
- Reset:
  - state = e_ready, sync_cnt_o = 0.
  - All v_o and ready_and_o outputs are 0 during reset.
  - Reset mid-operation abandons any pending ack or forward; nothing is resumed.
- FSM states: e_ready, e_send_ack, e_fwd_data.
- e_ready, sync command (header msg_type.cmd == e_bedrock_cmd_sync):
  - lce_cmd_header_ready_and_o = 1 unconditionally; no forward valid is raised.
  - On the header handshake, latch src_id and addr, then go to e_send_ack.
  - A sync command with has_data_i = 1 is illegal; flag it with an assertion.
- e_ready, any other command:
  - Header passes combinationally: fwd_cmd_header_o, fwd_cmd_has_data_o and fwd_cmd_header_v_o follow the input, and header ready = fwd_cmd_header_ready_and_i.
  - On the handshake, go to e_fwd_data if has_data_i = 1, otherwise stay in e_ready.
- e_send_ack:
  - lce_resp_header_v_o = 1, held stable until the handshake. Input header ready = 0.
  - Response header fields:
    - msg_type.resp = e_bedrock_resp_sync_ack
    - payload.src_id = lce_id_i
    - payload.dst_id = latched src_id
    - addr = latched addr
    - size = e_bedrock_msg_size_1
    - all other fields 0
  - On the handshake: sync_cnt_o += 1, saturating at num_cce_p; go to e_ready.
  - Latency: ack valid rises the cycle after the sync header handshake. Minimum sync-to-sync spacing is 2 cycles.
- e_fwd_data:
  - Data passes combinationally: fwd data/v/last follow the input, and data ready = fwd_cmd_data_ready_and_i. Header ready = 0.
  - On a data handshake with last_i = 1, go to e_ready.
- Data ready is 0 in every state other than e_fwd_data.
- Counter boundaries:
  - A sync arriving with sync_cnt_o == num_cce_p is still acked; the count stays at num_cce_p (saturate, no wrap).
  - sync_done_o is combinational from sync_cnt_o.
- Back-pressure: a stalled response or forward path stalls only the input channel. No header or data is dropped or duplicated.

Test Plan:
- Reset, then one sync header from cce 2 with lce_id_i = 5 → cycle+1: resp valid with dst_id = 2, src_id = 5, type sync_ack; after the handshake sync_cnt_o = 1.
- num_cce_p = 4 syncs, with resp ready_and held 0 for 3 cycles on the second → exactly 4 acks, header stable while stalled, sync_done_o rises on the 4th ack handshake.
- A 5th sync after done → acked; sync_cnt_o stays 4.
- Non-sync command with a 4-beat payload, downstream ready toggling every cycle → all 4 beats forwarded in order, last on beat 4, no resp valid.
- Sync immediately following a data command's last beat → that sync is not accepted until the cycle after last; ack issued; forwarded stream intact.
- Reset asserted while in e_send_ack → next cycle resp valid = 0, sync_cnt_o = 0, state e_ready.
